multi_access_stall_ctrl: RTL and testbench

Parametrised pipeline stall controller for the MEM stage. It sequences an instruction that needs up to MAX_ACCESSES back-to-back data-memory accesses (plain load/store = 1, LDI/STI = 2, deeper indirection for future ISA extensions). It drives the data-memory request lines and the access index used by the datapath's address mux. It freezes the pipeline until every access and the instruction fetch have completed, and it keeps a stale response from being counted twice.

---
 rtl/stall_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/multi_access_stall_ctrl.sv | 119 +++++++++++
 tb/tb_multi_access_stall_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stall_pkg.sv
// Shared types and width helpers for the MEM-stage multi-access stall controller.
package stall_pkg;

    typedef enum logic [1:0] {
        S_ACCESS,
        S_GAP,
        S_RELEASE
    } stall_state_e;

    function automatic int acc_w(input int max_acc);
        return $clog2(max_acc + 1);
    endfunction

    function automatic int idx_w(input int max_acc);
        return (max_acc > 1) ? $clog2(max_acc) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// CNT_W-wide saturating incrementer with synchronous clear.
// Only compiled when STALL_PERF_EN is defined.
`ifdef STALL_PERF_EN
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`endif

// File: rtl/multi_access_stall_ctrl.sv
// MEM-stage stall controller sequencing up to MAX_ACCESSES data accesses per instruction.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_EN.
module multi_access_stall_ctrl
    import stall_pkg::*;
#(
    parameter int  MAX_ACCESSES = 2,
    parameter int  CNT_W        = 16,
    localparam int ACC_W        = acc_w(MAX_ACCESSES),
    localparam int IDX_W        = idx_w(MAX_ACCESSES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifetch_resp,
    input  logic             dmem_need,
    input  logic [ACC_W-1:0] num_accesses,
    input  logic             last_is_write,
    input  logic             mem_resp,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [IDX_W-1:0] access_idx,
    output logic             stall_pipeline,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [ACC_W-1:0] MAX_NUM = ACC_W'(MAX_ACCESSES);

    stall_state_e     r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_held;

    logic [ACC_W-1:0] w_num;
    logic             w_active;
    logic             w_final;
    logic             w_read;
    logic             w_write;
    logic             w_stall;

    always_comb begin
        w_num    = (num_accesses > MAX_NUM) ? MAX_NUM : num_accesses;
        w_active = dmem_need & (w_num != '0);
        // >= rather than == so an index past the end can never run away
        w_final  = (ACC_W'(r_idx) >= (w_num - ACC_W'(1)));
        w_read   = 1'b0;
        w_write  = 1'b0;
        w_stall  = 1'b1;
        case (r_state)
            S_ACCESS: begin
                w_read  = w_active & ~(w_final & last_is_write);
                w_write = w_active & w_final & last_is_write;
                w_stall = ~ifetch_resp | (w_active & (~mem_resp | ~w_final));
            end
            S_GAP:     w_stall = 1'b1;
            S_RELEASE: w_stall = mem_resp | ~ifetch_resp;
            default:   w_stall = 1'b1;
        endcase
        if (rst) begin
            w_read  = 1'b0;
            w_write = 1'b0;
            w_stall = 1'b1;
        end
    end

    // r_held marks a final response that arrived while the fetch was missing:
    // the instruction has not advanced yet, so S_RELEASE must wait for the fetch
    // before returning to S_ACCESS, otherwise the same access would be reissued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCESS;
            r_idx   <= '0;
            r_held  <= 1'b0;
        end else begin
            case (r_state)
                S_ACCESS: begin
                    if (w_active && mem_resp) begin
                        if (w_final) begin
                            r_state <= S_RELEASE;
                            r_held  <= ~ifetch_resp;
                        end else begin
                            r_state <= S_GAP;
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (!mem_resp) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_RELEASE: begin
                    if (!mem_resp && (!r_held || ifetch_resp)) begin
                        r_state <= S_ACCESS;
                        r_idx   <= '0;
                        r_held  <= 1'b0;
                    end
                end
                default: r_state <= S_ACCESS;
            endcase
        end
    end

    assign dmem_read      = w_read;
    assign dmem_write     = w_write;
    assign stall_pipeline = w_stall;
    assign access_idx     = r_idx;

`ifdef STALL_PERF_EN
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .i_clk  (clk),
        .i_clr  (rst),
        .i_inc  (w_stall),
        .o_count(stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_multi_access_stall_ctrl.sv
// Scoreboard bench for multi_access_stall_ctrl: directed scenarios followed by
// randomized instructions against a behavioural model of the access sequencing rules.
module tb_multi_access_stall_ctrl;

    localparam int MAX_ACC = 4;
    localparam int CNT_W   = 4;
    localparam int ACC_W   = 3;
    localparam int IDX_W   = 2;
    localparam int SAT     = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ifetch_resp = 1'b1;
    logic             dmem_need = 1'b0;
    logic [ACC_W-1:0] num_accesses = '0;
    logic             last_is_write = 1'b0;
    logic             mem_resp = 1'b0;
    logic             dmem_read;
    logic             dmem_write;
    logic [IDX_W-1:0] access_idx;
    logic             stall_pipeline;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    multi_access_stall_ctrl #(
        .MAX_ACCESSES(MAX_ACC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifetch_resp   (ifetch_resp),
        .dmem_need     (dmem_need),
        .num_accesses  (num_accesses),
        .last_is_write (last_is_write),
        .mem_resp      (mem_resp),
        .dmem_read     (dmem_read),
        .dmem_write    (dmem_write),
        .access_idx    (access_idx),
        .stall_pipeline(stall_pipeline),
        .stall_cycles  (stall_cycles)
    );

    typedef struct {
        logic rd;
        logic wr;
        logic st;
        int   idx;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: which access of the instruction we are on, whether we wait for the
    // response to drop between accesses, and whether the instruction is being retired.
    int m_idx = 0, n_idx;
    bit m_gap = 0, n_gap;
    bit m_rel = 0, n_rel;
    bit m_held = 0, n_held;
    int m_cnt = 0, n_cnt;
    bit last_stall = 1'b1;

    function automatic exp_t predict(input bit rs, input bit ifv, input bit nd,
                                     input int nm, input bit lw, input bit rp);
        exp_t e;
        int   eff;
        bit   act;
        bit   fin;
        eff = (nm > MAX_ACC) ? MAX_ACC : nm;
        act = nd && (eff > 0);
        fin = act && (m_idx >= eff - 1);
        n_idx = m_idx; n_gap = m_gap; n_rel = m_rel; n_held = m_held;
        e.idx = m_idx;
        e.rd  = 1'b0;
        e.wr  = 1'b0;
        e.st  = 1'b1;
        if (rs) begin
            n_idx = 0; n_gap = 0; n_rel = 0; n_held = 0;
        end else if (m_gap) begin
            if (!rp) n_gap = 0;
        end else if (m_rel) begin
            e.st = rp || !ifv;
            if (!rp && (!m_held || ifv)) begin
                n_rel = 0; n_idx = 0; n_held = 0;
            end
        end else begin
            e.rd = act && !(fin && lw);
            e.wr = act && fin && lw;
            e.st = !ifv || (act && !rp) || (act && !fin);
            if (act && rp) begin
                if (fin) begin
                    n_rel = 1; n_held = !ifv;
                end else begin
                    n_gap = 1; n_idx = m_idx + 1;
                end
            end
        end
        n_cnt = rs ? 0 : ((m_cnt + int'(e.st) > SAT) ? SAT : m_cnt + int'(e.st));
`ifdef STALL_PERF_EN
        e.cyc = m_cnt;
`else
        e.cyc = 0;
`endif
        return e;
    endfunction

    task automatic step(input bit rs, input bit ifv, input bit nd,
                        input int nm, input bit lw, input bit rp);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = rs;
        ifetch_resp   = ifv;
        dmem_need     = nd;
        num_accesses  = ACC_W'(nm);
        last_is_write = lw;
        mem_resp      = rp;
        e = predict(rs, ifv, nd, nm, lw, rp);
        sb.push_back(e);
        m_idx = n_idx; m_gap = n_gap; m_rel = n_rel; m_held = n_held; m_cnt = n_cnt;
        last_stall = e.st;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            check("dmem_read",      32'(dmem_read),      32'(me.rd));
            check("dmem_write",     32'(dmem_write),     32'(me.wr));
            check("stall_pipeline", 32'(stall_pipeline), 32'(me.st));
            check("access_idx",     32'(access_idx),     32'(me.idx));
            check("stall_cycles",   32'(stall_cycles),   32'(me.cyc));
        end
    end

    initial begin
        bit   c_need;
        int   c_num;
        bit   c_lw;
        bit   rs;
        bit   ifv;
        bit   rp;
        int   lat;
        int   hold;
        exp_t e0;

        repeat (3) step(1, 1, 0, 0, 0, 0);
        // plain load, response on the third request cycle
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        // STI with single-cycle responses
        step(0, 1, 1, 2, 1, 1);
        step(0, 1, 1, 2, 1, 0);
        step(0, 1, 1, 2, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        // final response held for three cycles
        step(0, 1, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        // fetch missing during the final data response
        step(0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 1);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // reset while waiting in the gap of a 4-access instruction
        step(0, 1, 1, 4, 0, 1);
        step(0, 1, 1, 4, 0, 1);
        step(1, 1, 1, 4, 0, 1);
        step(0, 1, 0, 4, 0, 0);
        // clamp of an oversized access count
        for (int i = 0; i < 12; i++) step(0, 1, 1, 7, 1, (i % 2) == 0);
        step(0, 1, 0, 0, 0, 0);
        // long fetch miss drives the counter into saturation
        repeat (20) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        c_need = 0; c_num = 0; c_lw = 0; lat = 0; hold = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!last_stall) begin
                c_need = $urandom_range(0, 3) != 0;
                c_num  = $urandom_range(0, 7);
                c_lw   = $urandom_range(0, 1);
            end
            rs  = ($urandom_range(0, 149) == 0);
            ifv = ($urandom_range(0, 3) != 0);
            rp  = 1'b0;
            if (hold > 0) begin
                rp = 1'b1;
                hold--;
            end else begin
                e0 = predict(rs, ifv, c_need, c_num, c_lw, 1'b0);
                if (e0.rd || e0.wr) begin
                    if (lat == 0) begin
                        rp   = 1'b1;
                        hold = $urandom_range(0, 2);
                        lat  = $urandom_range(0, 2);
                    end else begin
                        lat--;
                    end
                end
            end
            step(rs, ifv, c_need, c_num, c_lw, rp);
        end
        step(0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
